// File: rtl/iterative_multiplier.sv
// iterative_multiplier: handshaked unsigned WIDTH x WIDTH -> 2*WIDTH multiplier.
// Operand B is consumed CHUNK bits per cycle (LSB slice first), one
// multiply-accumulate per cycle, so one operation takes N = WIDTH/CHUNK MAC
// cycles plus one DONE cycle. A sideband tag travels with each operation.
// Optional feature macro: MUL_ADDEND_EN adds a 2*WIDTH addend port in_c and
// produces (A*B + C) mod 2^(2*WIDTH), folded into the DONE-entry load.
module iterative_multiplier #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
`ifdef MUL_ADDEND_EN
  input  logic [2*WIDTH-1:0] in_c,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam bit PARAM_OK = (CHUNK >= 1) && (CHUNK <= WIDTH) && ((WIDTH % CHUNK) == 0);
  localparam int N        = PARAM_OK ? (WIDTH / CHUNK) : 1;
  localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam int PW       = WIDTH + CHUNK;  // width of the accumulator slice that receives A*b_i
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // Reject slice sizes that do not tile the operand exactly.
  if (!PARAM_OK) begin : g_bad_param
    $error("iterative_multiplier: WIDTH=%0d CHUNK=%0d TAG_W=%0d, CHUNK must divide WIDTH",
           WIDTH, CHUNK, TAG_W);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_shift;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [TAG_W-1:0]     tag_reg;
  logic [CNT_W-1:0]     cnt;
  logic [CHUNK-1:0]     b_slice;
  logic [PW-1:0]        partial;
  logic                 accept;
  logic                 last_step;
`ifdef MUL_ADDEND_EN
  logic [2*WIDTH-1:0]   c_reg;
`endif

  // One MAC step: shift the accumulator down one slice, then add A*b_i at the top.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    b_slice   = b_reg[int'(cnt) * CHUNK +: CHUNK];
    partial   = PW'(a_reg) * PW'(b_slice);
    acc_shift = acc >> CHUNK;
    acc_next  = acc_shift;
    acc_next[2*WIDTH-1 -: PW] = acc_shift[2*WIDTH-1 -: PW] + partial;
  end

  // Final value presented on the output registers when DONE is entered.
`ifdef MUL_ADDEND_EN
  assign result = acc_next + c_reg;
`else
  assign result = acc_next;
`endif

  assign last_step = (cnt == LAST);
  assign out_valid = (state == DONE);

  // Handshake and next-state decode.
  always_comb begin
    state_next = state;
    in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
    accept     = in_valid && in_ready;
    unique case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (last_step) state_next = DONE;
      DONE: if (out_ready) state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight, dropping a pending result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Operand capture, accumulation and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      tag_reg     <= '0;
      cnt         <= '0;
      out_product <= '0;
      out_tag     <= '0;
`ifdef MUL_ADDEND_EN
      c_reg       <= '0;
`endif
    end else if (accept) begin
      a_reg   <= in_a;
      b_reg   <= in_b;
      tag_reg <= in_tag;
      acc     <= '0;
      cnt     <= '0;
`ifdef MUL_ADDEND_EN
      c_reg   <= in_c;
`endif
    end else if (state == RUN) begin
      acc <= acc_next;
      cnt <= cnt + CNT_W'(1);
      if (last_step) begin
        out_product <= result;
        out_tag     <= tag_reg;
      end
    end
  end

endmodule
